// File: rtl/synchronizer_debounce.sv
// -----------------------------------------------------------------------------
// synchronizer_debounce
//
// Brings NCH asynchronous inputs into the clk domain through an NSTAGES-deep
// flop chain each, then debounces every channel: a new level is accepted only
// after it has been seen on DB_CYCLES consecutive rising edges. An accepted
// change can be flagged with single-cycle rise/fall pulses.
//
// Optional feature macro: SYNCHRONIZER_DEBOUNCE_EDGE_EN
//   defined   -> rise/fall are registered edge pulses
//   undefined -> rise/fall are present but tied to 0 (no flops)
//
// Parameters:
//   NCH       number of independent channels (1..16)
//   NSTAGES   synchronizer stages per channel (2..4)
//   DB_CYCLES stable edges required to accept a new level (1..255)
//
// Ports:
//   clk    in   sole clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   d      in   [NCH] raw asynchronous inputs
//   q      out  [NCH] synchronized, debounced level
//   rise   out  [NCH] one-cycle pulse on accepted 0->1
//   fall   out  [NCH] one-cycle pulse on accepted 1->0
// -----------------------------------------------------------------------------
module synchronizer_debounce #(
    parameter int NCH       = 4,
    parameter int NSTAGES   = 2,
    parameter int DB_CYCLES = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] d,
    output logic [NCH-1:0] q,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall
);

    localparam int            CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    // The per-channel state is implied by comparing s with q, so it needs no
    // register of its own; the enum just names the two cases.
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } ch_state_e;

    logic [NCH-1:0] chain [NSTAGES];
    logic [NCH-1:0] s;
    logic [CW-1:0]  cnt_r   [NCH];
    logic [CW-1:0]  cnt_nxt [NCH];
    logic [NCH-1:0] q_r;
    logic [NCH-1:0] q_nxt;
    ch_state_e      st [NCH];

    // Synchronizer: plain flop-to-flop chain, nothing in between stages.
    // NOTE: every flop, the chain included, is cleared by the async reset so
    // that no stale metastable-era sample survives into the debouncer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NSTAGES; j++) chain[j] <= '0;
        end else begin
            chain[0] <= d;
            for (int j = 1; j < NSTAGES; j++) chain[j] <= chain[j-1];
        end
    end

    assign s = chain[NSTAGES-1];

    // Next-state logic for the debounce counters and levels.
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        q_nxt = q_r;
        for (int i = 0; i < NCH; i++) begin
            cnt_nxt[i] = '0;
            st[i]      = (s[i] == q_r[i]) ? ST_STABLE : ST_PENDING;
            case (st[i])
                ST_STABLE: cnt_nxt[i] = '0;  // a glitch that ended is forgotten
                ST_PENDING: begin
                    if (cnt_r[i] == CNT_MAX) begin
                        q_nxt[i] = s[i];     // stable long enough: accept
                    end else begin
                        cnt_nxt[i] = cnt_r[i] + CW'(1);
                    end
                end
                default: cnt_nxt[i] = '0;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= '0;
            for (int i = 0; i < NCH; i++) cnt_r[i] <= '0;
        end else begin
            q_r <= q_nxt;
            for (int i = 0; i < NCH; i++) cnt_r[i] <= cnt_nxt[i];
        end
    end

    assign q = q_r;

`ifdef SYNCHRONIZER_DEBOUNCE_EDGE_EN
    logic [NCH-1:0] rise_r;
    logic [NCH-1:0] fall_r;

    // Pulses are registered alongside q, so they are high exactly in the
    // cycle where q shows its new value. q only moves one way per edge, so
    // rise and fall can never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_r <= '0;
            fall_r <= '0;
        end else begin
            rise_r <= q_nxt & ~q_r;
            fall_r <= ~q_nxt & q_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule
